// File: rtl/button_event_arbiter.sv
`timescale 1ns/1ps
// button_event_arbiter
// Synchronises, debounces and classifies NUM_BTN raw buttons on a shared
// tick, then arbitrates short/long press events into a small FIFO.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   btn_in     raw active-high buttons, asynchronous to clk
//   evt_valid  FIFO head holds an event
//   evt_ready  consumer accepts the head this cycle
//   evt_id     button index of the head event
//   evt_long   1 = long press, 0 = short press
//   overflow   sticky: an event was dropped (cleared only by rst)
//   busy       some button is between press debounce and release debounce
//   dbg_state  per-button FSM state, 3 bits per button (button i at [3*i +: 3])
//
// Handshake: an event transfers on every clk edge where evt_valid and
// evt_ready are both high. While evt_valid is high and evt_ready is low,
// evt_valid, evt_id and evt_long hold their values. evt_valid never depends
// combinationally on evt_ready.
module button_event_arbiter #(
    parameter int NUM_BTN        = 4,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 5000,
    parameter int FIFO_DEPTH     = 4,
    localparam int ID_W          = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BTN-1:0]     btn_in,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [ID_W-1:0]        evt_id,
    output logic                   evt_long,
    output logic                   overflow,
    output logic                   busy,
    output logic [3*NUM_BTN-1:0]   dbg_state
);

    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW    = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HW    = $clog2(LONG_TICKS + 1);
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PW + 1;

    typedef enum logic [2:0] {
        ARMING      = 3'd0,
        IDLE        = 3'd1,
        DEB_PRESS   = 3'd2,
        HELD        = 3'd3,
        LONG_DONE   = 3'd4,
        DEB_RELEASE = 3'd5
    } btn_state_t;

    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [NUM_BTN-1:0] sync1_q, sync2_q;

    btn_state_t         state_q [NUM_BTN];
    btn_state_t         state_d [NUM_BTN];
    logic [CW-1:0]      cnt_q   [NUM_BTN];
    logic [CW-1:0]      cnt_d   [NUM_BTN];
    logic [HW-1:0]      hold_q  [NUM_BTN];
    logic [HW-1:0]      hold_d  [NUM_BTN];
    logic [NUM_BTN-1:0] short_q, short_d;
    logic [NUM_BTN-1:0] post, post_long;

    logic [NUM_BTN-1:0] pending_q, kind_q;
    logic               found;
    logic [ID_W-1:0]    gid;

    logic [ID_W-1:0]       mem_id   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_long;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full, empty, push, pop;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    // Per-button FSM. A level change is acted on in any cycle; counting
    // only advances on tick. The hold count is kept across release bounces
    // so a short glitch while held neither restarts nor ends the press.
    always_comb begin
        post      = '0;
        post_long = '0;
        short_d   = short_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            hold_d[i]  = hold_q[i];
            case (state_q[i])
                ARMING: begin
                    if (sync2_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (tick) begin
                        if (cnt_q[i] == CW'(DEBOUNCE_TICKS - 1)) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = DEB_PRESS;
                        cnt_d[i]   = '0;
                    end
                end
                DEB_PRESS: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (tick) begin
                        if (cnt_q[i] == CW'(DEBOUNCE_TICKS - 1)) begin
                            state_d[i] = HELD;
                            cnt_d[i]   = '0;
                            hold_d[i]  = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = DEB_RELEASE;
                        short_d[i] = 1'b1;
                        cnt_d[i]   = '0;
                    end else if (tick) begin
                        if (hold_q[i] == HW'(LONG_TICKS - 1)) begin
                            state_d[i]   = LONG_DONE;
                            post[i]      = 1'b1;
                            post_long[i] = 1'b1;
                        end else begin
                            hold_d[i] = hold_q[i] + 1'b1;
                        end
                    end
                end
                LONG_DONE: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = DEB_RELEASE;
                        short_d[i] = 1'b0;
                        cnt_d[i]   = '0;
                    end
                end
                DEB_RELEASE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = short_q[i] ? HELD : LONG_DONE;
                        cnt_d[i]   = '0;
                    end else if (tick) begin
                        if (cnt_q[i] == CW'(DEBOUNCE_TICKS - 1)) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                            post[i]    = short_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[i] = ARMING;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Fixed-priority pick of the lowest pending button.
    always_comb begin
        found = 1'b0;
        gid   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (pending_q[i] && !found) begin
                found = 1'b1;
                gid   = ID_W'(i);
            end
        end
    end

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = !empty && evt_ready;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign push  = found && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            short_q   <= '0;
            pending_q <= '0;
            kind_q    <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= ARMING;
                cnt_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            short_q  <= short_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                hold_q[i]  <= hold_d[i];
                // A new event on a button whose previous event is still
                // waiting is dropped; the waiting one keeps its kind.
                if (post[i] && pending_q[i]) begin
                    overflow <= 1'b1;
                end
                if (post[i] && !pending_q[i]) begin
                    pending_q[i] <= 1'b1;
                    kind_q[i]    <= post_long[i];
                end else if (push && (gid == ID_W'(i))) begin
                    pending_q[i] <= 1'b0;
                end
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the outputs are gated while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]   <= gid;
            mem_long[wr_ptr] <= kind_q[gid];
        end
    end

    assign evt_valid = !empty;
    assign evt_id    = evt_valid ? mem_id[rd_ptr] : '0;
    assign evt_long  = evt_valid ? mem_long[rd_ptr] : 1'b0;

    always_comb begin
        busy      = 1'b0;
        dbg_state = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (state_q[i] != IDLE && state_q[i] != ARMING) busy = 1'b1;
            dbg_state[3*i +: 3] = state_q[i];
        end
    end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
Front-end controller for all user buttons of the pet console. Synchronises and debounces NUM_BTN raw buttons on a shared millisecond tick and classifies each press as short or long. Events are arbitrated into a small FIFO and handed to the game FSM over a valid/ready handshake, so the FSM consumes one ordered event stream instead of polling per-button detectors.

Parameters:
NUM_BTN, 4, number of button inputs
TICK_DIV, 50000, clk cycles per tick (1 ms at 50 MHz)
DEBOUNCE_TICKS, 20, consecutive stable ticks needed to accept a level change
LONG_TICKS, 5000, held ticks after debounce that make a long press (5 s)
FIFO_DEPTH, 4, output event FIFO entries (power of two)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  reset, synchronous, active-high
btn_in  in  NUM_BTN  raw active-high buttons, asynchronous to clk
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts head this cycle
evt_id  out  $clog2(NUM_BTN)  button index of head event
evt_long  out  1  1 = long press, 0 = short press
overflow  out  1  sticky: an event was dropped; cleared only by rst
busy  out  1  OR of all button FSMs not in IDLE/ARMING

Behaviour:
- Reset (rst high at a clk edge): tick counter 0, sync flops 0, all button FSMs to ARMING, counters 0, pending flags 0, FIFO empty. All outputs 0 after that edge. Reset mid-hold gives no event.
- Sync: 2-flop synchroniser per button; FSMs see only the synced level.
- Tick: counter 0..TICK_DIV-1; tick is a 1-clk pulse when counter == TICK_DIV-1, then the counter wraps to 0. All debounce/hold counting advances only on tick.
- Per-button FSM (states ARMING, IDLE, DEB_PRESS, HELD, LONG_DONE, DEB_RELEASE):
  - ARMING: count ticks while synced low. On reaching DEBOUNCE_TICKS go to IDLE. A high level clears the count. This stops a button held through reset from firing.
  - IDLE: synced high -> DEB_PRESS with count 0.
  - DEB_PRESS: on each tick with level high, count+1. Reaching DEBOUNCE_TICKS -> HELD, hold=0. Low at any cycle -> IDLE with no event.
  - HELD: hold+1 per tick. When hold reaches LONG_TICKS, post a long event and go to LONG_DONE. Low -> DEB_RELEASE with short_flag=1; hold is frozen.
  - LONG_DONE: low -> DEB_RELEASE with short_flag=0.
  - DEB_RELEASE: count low ticks. Reaching DEBOUNCE_TICKS -> IDLE, posting a short event if short_flag. High before that -> return to HELD (hold resumes) or LONG_DONE per short_flag.
- Post: sets pending[i] and kind[i] on the edge after detection. If pending[i] is already set, the new event is dropped and overflow is set.
- Arbiter: fixed priority, lowest index first. Grants one pending button per cycle when the FIFO can accept. The granted pending bit clears on the same edge as the FIFO write.
- FIFO: first-word-fall-through. evt_valid = !empty; evt_id/evt_long show the head. Pop when evt_valid && evt_ready. Push is allowed when !full, or when full with a pop in the same cycle. Pointers wrap modulo FIFO_DEPTH.
- Latency: detection edge D -> pending visible D+1 -> FIFO write at edge ending D+1 -> evt_valid high in cycle D+2 (if the FIFO was empty and there is no higher-priority pending).
- Outputs are held stable while evt_valid && !evt_ready.

Test Plan:
Use TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=10, FIFO_DEPTH=4 unless noted.
- Short press: btn_in[2] high for 8 ticks, then low for 3 ticks -> exactly one event {id=2, long=0}, evt_valid 2 clks after the release debounce completes; no event while the button is held.
- Long press: btn_in[1] high for 20 ticks -> {id=1, long=1} posted 13 ticks after the rise (3 debounce + 10 hold). Release then gives no second event.
- Bounce: btn_in[0] pulses high for 2 ticks, 5 times -> no events, busy toggles, FIFO stays empty. A 1-tick low glitch while HELD -> still a single short event.
- Simultaneous: buttons 3 and 0 complete short releases on the same clk -> id 0 enters the FIFO first, id 3 one clk later.
- Backpressure: evt_ready=0 with 6 short events from buttons 0..3 -> 4 entries queue, button pending holds 1 more, the next event from an already-pending button sets overflow=1. Raising evt_ready drains in order with 1 event/clk.
- Reset mid-hold: rst during HELD of button 2 with btn_in held high for 10 more ticks, then released -> no event; the button must be stable low for 3 ticks (ARMING) before a new press is recognised.
